// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame timer.
// RX_MAJORITY_SAMPLE_EN selects three-point majority sampling and a higher minimum prescale.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } rx_state_e;

  typedef logic [1:0] sample_idx_t;

  localparam sample_idx_t SAMPLE_EARLY = 2'd0;
  localparam sample_idx_t SAMPLE_MID   = 2'd1;
  localparam sample_idx_t SAMPLE_LATE  = 2'd2;

`ifdef RX_MAJORITY_SAMPLE_EN
  // mid-1 and mid+1 must both land inside the bit
  localparam int unsigned MIN_PRESC = 4;
`else
  localparam int unsigned MIN_PRESC = 2;
`endif

endpackage

// File: rtl/uart_rx_sample_decode.sv
// Combinational sample-point decode from the current edge position and latched prescale.
// RX_MAJORITY_SAMPLE_EN: strobes at mid-1/mid/mid+1, otherwise mid only.
module uart_rx_sample_decode
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic [PRESC_W-1:0] i_edge,
  input  logic [PRESC_W-1:0] i_p_lat,
  input  rx_state_e          i_state,
  output logic               o_strobe,
  output sample_idx_t        o_idx
);

  logic [PRESC_W-1:0] w_mid;
  assign w_mid = i_p_lat >> 1;

`ifdef RX_MAJORITY_SAMPLE_EN
  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  always_comb begin
    o_strobe = 1'b0;
    o_idx    = '0;
    if (i_state == COUNT) begin
      if (i_edge == w_mid - ONE) begin
        o_strobe = 1'b1;
        o_idx    = SAMPLE_EARLY;
      end else if (i_edge == w_mid) begin
        o_strobe = 1'b1;
        o_idx    = SAMPLE_MID;
      end else if (i_edge == w_mid + ONE) begin
        o_strobe = 1'b1;
        o_idx    = SAMPLE_LATE;
      end
    end
  end
`else
  always_comb begin
    o_strobe = 1'b0;
    o_idx    = '0;
    if (i_state == COUNT && i_edge == w_mid) begin
      o_strobe = 1'b1;
      o_idx    = SAMPLE_MID;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_frame_timer.sv
// Oversampling edge/bit counter and frame FSM for the UART receiver.
// RX_MAJORITY_SAMPLE_EN (via uart_rx_pkg / decode) enables three-point sampling.
module uart_rx_frame_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Enable,
  input  logic               Resync,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [BIT_W-1:0]   Frame_Len,
  output logic [PRESC_W-1:0] edge_count,
  output logic [BIT_W-1:0]   bit_count,
  output logic               sample_strobe,
  output logic [1:0]         sample_idx,
  output logic               bit_done,
  output logic               frame_done,
  output logic               cfg_err
);

  localparam logic [PRESC_W-1:0] ONE_P = PRESC_W'(1);
  localparam logic [BIT_W-1:0]   ONE_B = BIT_W'(1);

  rx_state_e          r_state;
  logic [PRESC_W-1:0] r_edge, r_p_lat;
  logic [BIT_W-1:0]   r_bit, r_l_lat;
  logic               r_cfg_err;

  logic w_cfg_ok, w_last_edge, w_last_bit;

  assign w_cfg_ok    = (Prescale >= PRESC_W'(MIN_PRESC)) && (Frame_Len != '0);
  assign w_last_edge = (r_edge == r_p_lat - ONE_P);
  assign w_last_bit  = (r_bit == r_l_lat - ONE_B);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_edge    <= '0;
      r_bit     <= '0;
      r_p_lat   <= '0;
      r_l_lat   <= '0;
      r_cfg_err <= 1'b0;
    end else if (!Enable) begin
      r_state <= IDLE;
      r_edge  <= '0;
      r_bit   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cfg_ok) begin
            r_p_lat   <= Prescale;
            r_l_lat   <= Frame_Len;
            r_cfg_err <= 1'b0;
            r_state   <= COUNT;
          end else begin
            r_cfg_err <= 1'b1;
          end
        end
        COUNT: begin
          if (Resync) begin
            r_edge <= '0;
            r_bit  <= '0;
          end else if (w_last_edge) begin
            r_edge <= '0;
            // park bit_count at the frame length so HOLD reports it
            if (w_last_bit) begin
              r_bit   <= r_l_lat;
              r_state <= HOLD;
            end else begin
              r_bit <= r_bit + ONE_B;
            end
          end else begin
            r_edge <= r_edge + ONE_P;
          end
        end
        HOLD: begin
          if (Resync) begin
            r_edge  <= '0;
            r_bit   <= '0;
            r_state <= COUNT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_rx_sample_decode #(.PRESC_W(PRESC_W)) u_decode (
    .i_edge   (r_edge),
    .i_p_lat  (r_p_lat),
    .i_state  (r_state),
    .o_strobe (sample_strobe),
    .o_idx    (sample_idx)
  );

  assign bit_done   = (r_state == COUNT) && w_last_edge;
  assign frame_done = bit_done && w_last_bit;
  assign edge_count = r_edge;
  assign bit_count  = r_bit;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Directed self-checking bench for uart_rx_frame_timer (either RX_MAJORITY_SAMPLE_EN build).
module tb_uart_rx_frame_timer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Enable = 1'b0;
  logic       Resync = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [3:0] Frame_Len = 4'd10;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       sample_strobe;
  logic [1:0] sample_idx;
  logic       bit_done;
  logic       frame_done;
  logic       cfg_err;

  int checks = 0;
  int passed = 0;

`ifdef RX_MAJORITY_SAMPLE_EN
  localparam bit MAJ = 1'b1;
  localparam logic [5:0] BAD_PRESC = 6'd3;
`else
  localparam bit MAJ = 1'b0;
  localparam logic [5:0] BAD_PRESC = 6'd1;
`endif

  uart_rx_frame_timer #(.PRESC_W(6), .BIT_W(4)) dut (
    .CLK(CLK), .RST(RST), .Enable(Enable), .Resync(Resync),
    .Prescale(Prescale), .Frame_Len(Frame_Len),
    .edge_count(edge_count), .bit_count(bit_count),
    .sample_strobe(sample_strobe), .sample_idx(sample_idx),
    .bit_done(bit_done), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // leaves the DUT in its first COUNT cycle
  task automatic start_frame(input logic [5:0] p, input logic [3:0] l);
    Enable = 1'b0;
    step();
    Prescale  = p;
    Frame_Len = l;
    Enable    = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [14:0] got;
    RST = 1'b0;
    #12;
    got = {edge_count, bit_count, sample_strobe, sample_idx, bit_done, frame_done, cfg_err};
    checks++;
    if (got !== 15'd0) $display("FAIL reset_outputs: got %h want 0", got);
    else passed++;
    RST = 1'b1;
    step();
    checks++;
    if ({edge_count, bit_count, cfg_err} !== 11'd0)
      $display("FAIL reset_idle: got e=%0d b=%0d err=%0d want 0", edge_count, bit_count, cfg_err);
    else passed++;
  endtask

  task automatic test_frame();
    logic [12:0] got, exp;
    int e, b;
    bit es;
    start_frame(6'd8, 4'd10);
    for (int c = 0; c < 80; c++) begin
      e = c % 8;
      b = c / 8;
      es = MAJ ? (e >= 3 && e <= 5) : (e == 4);
      exp = {6'(e), 4'(b), es, (e == 7), (c == 79)};
      got = {edge_count, bit_count, sample_strobe, bit_done, frame_done};
      checks++;
      if (got !== exp) $display("FAIL frame_c%0d: got %h want %h", c, got, exp);
      else passed++;
      if (es) begin
        checks++;
        if (sample_idx !== (MAJ ? 2'(e - 3) : 2'd1))
          $display("FAIL frame_idx_c%0d: got %0d want %0d", c, sample_idx, MAJ ? e - 3 : 1);
        else passed++;
      end
      if (c < 79) step();
    end
    for (int h = 0; h < 3; h++) begin
      step();
      checks++;
      if ({edge_count, bit_count, sample_strobe, bit_done, frame_done} !== {6'd0, 4'd10, 3'b000})
        $display("FAIL hold_%0d: got e=%0d b=%0d s=%0d bd=%0d fd=%0d want e=0 b=10 pulses 0",
                 h, edge_count, bit_count, sample_strobe, bit_done, frame_done);
      else passed++;
    end
    Enable = 1'b0;
    step();
    checks++;
    if ({edge_count, bit_count} !== 10'd0)
      $display("FAIL hold_exit: got e=%0d b=%0d want 0 0", edge_count, bit_count);
    else passed++;
  endtask

  task automatic test_odd_ratio();
    int e;
    bit es;
    start_frame(6'd5, 4'd2);
    for (int c = 0; c < 10; c++) begin
      e = c % 5;
      es = MAJ ? (e >= 1 && e <= 3) : (e == 2);
      checks++;
      if ({sample_strobe, bit_done} !== {es, (e == 4)})
        $display("FAIL odd_c%0d: got s=%0d bd=%0d want s=%0d bd=%0d",
                 c, sample_strobe, bit_done, es, (e == 4));
      else passed++;
      if (es) begin
        checks++;
        if (sample_idx !== (MAJ ? 2'(e - 1) : 2'd1))
          $display("FAIL odd_idx_c%0d: got %0d want %0d", c, sample_idx, MAJ ? e - 1 : 1);
        else passed++;
      end
      step();
    end
    checks++;
    if (bit_count !== 4'd2) $display("FAIL odd_hold: got b=%0d want 2", bit_count);
    else passed++;
  endtask

  task automatic test_presc_change();
    start_frame(6'd8, 4'd10);
    repeat (24) step();
    Prescale = 6'd16;
    repeat (7) step();
    checks++;
    if ({edge_count, bit_count, bit_done} !== {6'd7, 4'd3, 1'b1})
      $display("FAIL presc_hold_old: got e=%0d b=%0d bd=%0d want e=7 b=3 bd=1",
               edge_count, bit_count, bit_done);
    else passed++;
    step();
    checks++;
    if ({edge_count, bit_count} !== {6'd0, 4'd4})
      $display("FAIL presc_next_bit: got e=%0d b=%0d want e=0 b=4", edge_count, bit_count);
    else passed++;
    Enable = 1'b0;
    step();
    Enable = 1'b1;
    step();
    repeat (15) step();
    checks++;
    if ({edge_count, bit_count, bit_done} !== {6'd15, 4'd0, 1'b1})
      $display("FAIL presc_new: got e=%0d b=%0d bd=%0d want e=15 b=0 bd=1",
               edge_count, bit_count, bit_done);
    else passed++;
    step();
    checks++;
    if ({edge_count, bit_count} !== {6'd0, 4'd1})
      $display("FAIL presc_new_bit: got e=%0d b=%0d want e=0 b=1", edge_count, bit_count);
    else passed++;
  endtask

  task automatic test_resync();
    int n;
    start_frame(6'd8, 4'd10);
    repeat (21) step();
    checks++;
    if ({edge_count, bit_count} !== {6'd5, 4'd2})
      $display("FAIL resync_pos: got e=%0d b=%0d want e=5 b=2", edge_count, bit_count);
    else passed++;
    Resync = 1'b1;
    step();
    Resync = 1'b0;
    checks++;
    if ({edge_count, bit_count} !== 10'd0)
      $display("FAIL resync_zero: got e=%0d b=%0d want 0 0", edge_count, bit_count);
    else passed++;
    n = 0;
    while (!frame_done && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n !== 79) $display("FAIL resync_len: got %0d steps want 79", n);
    else passed++;
    // resync on the frame_done cycle restarts instead of entering HOLD
    Resync = 1'b1;
    step();
    Resync = 1'b0;
    checks++;
    if ({edge_count, bit_count} !== 10'd0)
      $display("FAIL resync_fd: got e=%0d b=%0d want 0 0", edge_count, bit_count);
    else passed++;
    step();
    checks++;
    if ({edge_count, bit_count} !== {6'd1, 4'd0})
      $display("FAIL resync_fd_run: got e=%0d b=%0d want e=1 b=0", edge_count, bit_count);
    else passed++;
  endtask

  task automatic test_cfg_err();
    Enable = 1'b0;
    step();
    Prescale  = BAD_PRESC;
    Frame_Len = 4'd10;
    Enable    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({cfg_err, edge_count, bit_count, sample_strobe, bit_done} !== {1'b1, 12'd0})
        $display("FAIL cfg_bad_presc_%0d: got err=%0d e=%0d b=%0d s=%0d want err=1 rest 0",
                 i, cfg_err, edge_count, bit_count, sample_strobe);
      else passed++;
    end
    Prescale  = 6'd8;
    Frame_Len = 4'd0;
    step();
    checks++;
    if ({cfg_err, edge_count} !== {1'b1, 6'd0})
      $display("FAIL cfg_bad_len: got err=%0d e=%0d want err=1 e=0", cfg_err, edge_count);
    else passed++;
    Frame_Len = 4'd10;
    step();
    checks++;
    if ({cfg_err, edge_count, bit_count} !== 11'd0)
      $display("FAIL cfg_good: got err=%0d e=%0d b=%0d want 0 0 0", cfg_err, edge_count, bit_count);
    else passed++;
    step();
    checks++;
    if (edge_count !== 6'd1) $display("FAIL cfg_count: got e=%0d want 1", edge_count);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [14:0] got;
    start_frame(6'd8, 4'd10);
    repeat (20) step();
    #2 RST = 1'b0;
    #1;
    got = {edge_count, bit_count, sample_strobe, sample_idx, bit_done, frame_done, cfg_err};
    checks++;
    if (got !== 15'd0) $display("FAIL rst_mid_frame: got %h want 0", got);
    else passed++;
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({edge_count, bit_count} !== 10'd0)
      $display("FAIL rst_release: got e=%0d b=%0d want 0 0", edge_count, bit_count);
    else passed++;
    step();
    step();
    checks++;
    if ({edge_count, bit_count} !== {6'd1, 4'd0})
      $display("FAIL rst_restart: got e=%0d b=%0d want e=1 b=0", edge_count, bit_count);
    else passed++;
  endtask

  task automatic test_enable_drop();
    start_frame(6'd8, 4'd10);
    repeat (35) step();
    checks++;
    if ({edge_count, bit_count} !== {6'd3, 4'd4})
      $display("FAIL en_pos: got e=%0d b=%0d want e=3 b=4", edge_count, bit_count);
    else passed++;
    Enable = 1'b0;
    step();
    checks++;
    if ({edge_count, bit_count, sample_strobe, bit_done, frame_done} !== 13'd0)
      $display("FAIL en_drop: got e=%0d b=%0d s=%0d bd=%0d want all 0",
               edge_count, bit_count, sample_strobe, bit_done);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_odd_ratio();
    test_presc_change();
    test_resync();
    test_cfg_err();
    test_async_reset();
    test_enable_drop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
